// File: rtl/ac_pkg.sv
// Shared encodings and widths for the air-conditioner controller and datapath.
// Holds mode/state enums plus the temperature and energy bus widths.
package ac_pkg;

   localparam int TEMP_W  = 9;
   localparam int POWER_W = 10;

   typedef enum logic [1:0] {
      MODE_WIND = 2'b00,
      MODE_COLD = 2'b01,
      MODE_HOT  = 2'b10
   } mode_e;

   typedef enum logic [1:0] {
      ST_OFF   = 2'b00,
      ST_START = 2'b01,
      ST_RUN   = 2'b10,
      ST_ALARM = 2'b11
   } state_e;

endpackage

// File: rtl/ac_ctrl_tick_gen.sv
// Prescaler producing a registered one-cycle strobe every TICK_DIV clocks.
// Ports: clk, rst (sync, active-high), tick_o (strobe while count = TICK_DIV-1).
module tick_gen #(
   parameter int unsigned TICK_DIV = 10_000_000
) (
   input  logic clk,
   input  logic rst,
   output logic tick_o
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick_q, tick_d;

   always_comb begin
      cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      // Registered strobe is high exactly while the counter sits at LAST.
      tick_d = (cnt_d == LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick_o = tick_q;

endmodule

// File: rtl/ac_ctrl.sv
// Button-driven controller for the climate datapath: power sequencing,
// mode/set-point editing, recharge and low-energy supervision.
// Ports: clk, rst, btn_* pulses, power_now in; on_off, mode_in, set_temp,
// power_in, state, low_alarm, tick out (all registered).
module ac_ctrl
   import ac_pkg::*;
#(
   parameter int unsigned          TICK_DIV      = 10_000_000,
   parameter int unsigned          STARTUP_TICKS = 20,
   parameter logic [TEMP_W-1:0]    TEMP_MIN      = 9'd160,
   parameter logic [TEMP_W-1:0]    TEMP_MAX      = 9'd300,
   parameter logic [TEMP_W-1:0]    TEMP_INIT     = 9'd250,
   parameter logic [TEMP_W-1:0]    TEMP_STEP     = 9'd5,
   parameter logic [POWER_W-1:0]   POWER_INIT    = 10'd100,
   parameter logic [POWER_W-1:0]   POWER_MAX     = 10'd999,
   parameter logic [POWER_W-1:0]   CHARGE_STEP   = 10'd10,
   parameter logic [POWER_W-1:0]   LOW_THRESH    = 10'd20
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               btn_power,
   input  logic               btn_mode,
   input  logic               btn_up,
   input  logic               btn_down,
   input  logic               btn_charge,
   input  logic [POWER_W-1:0] power_now,
   output logic               on_off,
   output logic [1:0]         mode_in,
   output logic [TEMP_W-1:0]  set_temp,
   output logic [POWER_W-1:0] power_in,
   output logic [1:0]         state,
   output logic               low_alarm,
   output logic               tick
);

   localparam int SW = (STARTUP_TICKS > 1) ? $clog2(STARTUP_TICKS + 1) : 1;

   state_e             state_q, state_d;
   logic [SW-1:0]      start_q, start_d;
   logic               on_off_q, on_off_d;
   mode_e              mode_q, mode_d;
   logic [TEMP_W-1:0]  temp_q, temp_d;
   logic [POWER_W-1:0] pin_q, pin_d;
   logic               alarm_q, alarm_d;

   logic [POWER_W:0]   chg_sum;
   logic [POWER_W-1:0] chg_sat;
   logic [TEMP_W:0]    up_sum, dn_dif;
   logic [TEMP_W-1:0]  up_sat, dn_sat;
   logic               empty, pwr_ok;

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk    (clk),
      .rst    (rst),
      .tick_o (tick)
   );

   assign empty  = (power_now == '0);
   assign pwr_ok = (pin_q != '0);

   // Saturating arithmetic with one extra bit so nothing wraps.
   always_comb begin
      chg_sum = {1'b0, pin_q} + {1'b0, CHARGE_STEP};
      chg_sat = (chg_sum > {1'b0, POWER_MAX}) ? POWER_MAX : chg_sum[POWER_W-1:0];
      up_sum  = {1'b0, temp_q} + {1'b0, TEMP_STEP};
      up_sat  = (up_sum > {1'b0, TEMP_MAX}) ? TEMP_MAX : up_sum[TEMP_W-1:0];
      dn_dif  = {1'b0, temp_q} - {1'b0, TEMP_STEP};
      dn_sat  = (dn_dif[TEMP_W] || dn_dif < {1'b0, TEMP_MIN}) ?
                TEMP_MIN : dn_dif[TEMP_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_OFF;
         start_q <= '0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
      end
   end

   always_comb begin
      state_d = state_q;
      start_d = start_q;
      unique case (state_q)
         ST_OFF: begin
            if (btn_power && pwr_ok) begin
               state_d = ST_START;
               start_d = SW'(STARTUP_TICKS);
            end
         end
         ST_START: begin
            if (btn_power) begin
               state_d = ST_OFF;
            end else if (tick) begin
               if (start_q <= SW'(1)) begin
                  state_d = ST_RUN;
                  start_d = '0;
               end else begin
                  start_d = start_q - 1'b1;
               end
            end
         end
         ST_RUN, ST_ALARM: begin
            if (empty || btn_power)
               state_d = ST_OFF;
            else if (power_now <= LOW_THRESH)
               state_d = ST_ALARM;
            else
               state_d = ST_RUN;
         end
         default: state_d = ST_OFF;
      endcase
   end

   always_comb begin
      mode_d = mode_q;
      temp_d = temp_q;
      pin_d  = pin_q;
      unique case (state_q)
         ST_OFF: begin
            // A power press that cannot start does not block charge.
            if (!(btn_power && pwr_ok) && btn_charge)
               pin_d = chg_sat;
         end
         ST_RUN, ST_ALARM: begin
            if (empty) begin
               pin_d = '0;
            end else if (btn_power) begin
               pin_d = power_now;
            end else if (btn_mode) begin
               unique case (mode_q)
                  MODE_WIND: mode_d = MODE_COLD;
                  MODE_COLD: mode_d = MODE_HOT;
                  default:   mode_d = MODE_WIND;
               endcase
            end else if (btn_up && !btn_down) begin
               temp_d = up_sat;
            end else if (btn_down && !btn_up) begin
               temp_d = dn_sat;
            end
         end
         default: ;
      endcase
      if (state_d == ST_OFF)
         mode_d = MODE_WIND;
      on_off_d = (state_d == ST_RUN) || (state_d == ST_ALARM);
      alarm_d  = (state_d == ST_ALARM);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         on_off_q <= 1'b0;
         mode_q   <= MODE_WIND;
         temp_q   <= TEMP_INIT;
         pin_q    <= POWER_INIT;
         alarm_q  <= 1'b0;
      end else begin
         on_off_q <= on_off_d;
         mode_q   <= mode_d;
         temp_q   <= temp_d;
         pin_q    <= pin_d;
         alarm_q  <= alarm_d;
      end
   end

   assign on_off    = on_off_q;
   assign mode_in   = mode_q;
   assign set_temp  = temp_q;
   assign power_in  = pin_q;
   assign state     = state_q;
   assign low_alarm = alarm_q;

endmodule

// File: tb/tb_ac_ctrl.sv
// Directed self-checking bench for ac_ctrl.
// Uses TICK_DIV=4 and STARTUP_TICKS=3 to keep startup short.
module tb_ac_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_power = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_up = 1'b0;
   logic       btn_down = 1'b0;
   logic       btn_charge = 1'b0;
   logic [9:0] power_now = 10'd500;
   logic       on_off;
   logic [1:0] mode_in;
   logic [8:0] set_temp;
   logic [9:0] power_in;
   logic [1:0] state;
   logic       low_alarm;
   logic       tick;

   int n_vec = 0;
   int n_err = 0;
   int nt;

   localparam int B_PWR = 0;
   localparam int B_MODE = 1;
   localparam int B_UP = 2;
   localparam int B_DN = 3;
   localparam int B_CHG = 4;
   localparam int B_UPDN = 5;

   ac_ctrl #(
      .TICK_DIV      (4),
      .STARTUP_TICKS (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_power  (btn_power),
      .btn_mode   (btn_mode),
      .btn_up     (btn_up),
      .btn_down   (btn_down),
      .btn_charge (btn_charge),
      .power_now  (power_now),
      .on_off     (on_off),
      .mode_in    (mode_in),
      .set_temp   (set_temp),
      .power_in   (power_in),
      .state      (state),
      .low_alarm  (low_alarm),
      .tick       (tick)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic press(input int b);
      btn_power  = (b == B_PWR);
      btn_mode   = (b == B_MODE);
      btn_up     = (b == B_UP) || (b == B_UPDN);
      btn_down   = (b == B_DN) || (b == B_UPDN);
      btn_charge = (b == B_CHG);
      step();
      btn_power  = 1'b0;
      btn_mode   = 1'b0;
      btn_up     = 1'b0;
      btn_down   = 1'b0;
      btn_charge = 1'b0;
   endtask

   // Waits for RUN, counting ticks seen while still in START.
   task automatic wait_run(input string tag, output int ticks);
      ticks = 0;
      for (int i = 0; i < 40; i++) begin
         if (state == 2'b10) break;
         if (state == 2'b01 && tick) ticks++;
         step();
      end
      chk({tag, "_state"}, state, 2'b10);
      chk({tag, "_ticks"}, ticks, 3);
      chk({tag, "_onoff"}, on_off, 1);
   endtask

   initial begin
      rst = 1'b1;
      step();
      step();
      chk("rst_state", state, 0);
      chk("rst_temp", set_temp, 250);
      chk("rst_pin", power_in, 100);
      chk("rst_onoff", on_off, 0);
      chk("rst_mode", mode_in, 0);
      chk("rst_alarm", low_alarm, 0);
      chk("rst_tick", tick, 0);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         chk($sformatf("tick_%0d", i), tick, (i % 4 == 2) ? 1 : 0);
      end
      chk("idle_state", state, 0);

      // Aborted start: on_off must stay low.
      press(B_PWR);
      chk("ab_start", state, 1);
      for (int i = 0; i < 2; i++) begin
         step();
         chk("ab_onoff", on_off, 0);
      end
      press(B_PWR);
      chk("ab_off", state, 0);
      chk("ab_onoff2", on_off, 0);

      press(B_PWR);
      chk("s1_start", state, 1);
      wait_run("s1", nt);

      for (int i = 0; i < 10; i++) press(B_UP);
      chk("up10", set_temp, 300);
      press(B_UP);
      chk("up11", set_temp, 300);
      for (int i = 0; i < 30; i++) press(B_DN);
      chk("dn30", set_temp, 160);
      press(B_UP);
      chk("up_from_min", set_temp, 165);
      press(B_UPDN);
      chk("updn", set_temp, 165);
      press(B_DN);
      chk("dn_to_min", set_temp, 160);
      press(B_MODE);
      chk("mode1", mode_in, 1);
      press(B_MODE);
      chk("mode2", mode_in, 2);
      press(B_MODE);
      chk("mode3", mode_in, 0);
      press(B_CHG);
      chk("chg_run", power_in, 100);

      // Leave with 995 remaining, then recharge toward the ceiling.
      power_now = 10'd995;
      press(B_PWR);
      chk("off995_state", state, 0);
      chk("off995_pin", power_in, 995);
      chk("off995_onoff", on_off, 0);
      press(B_CHG);
      chk("chg999", power_in, 999);
      press(B_CHG);
      chk("chg999b", power_in, 999);
      press(B_UP);
      chk("up_in_off", set_temp, 160);

      power_now = 10'd500;
      press(B_PWR);
      wait_run("s2", nt);
      power_now = 10'd0;
      step();
      chk("empty_state", state, 0);
      chk("empty_pin", power_in, 0);
      chk("empty_onoff", on_off, 0);
      chk("empty_temp", set_temp, 160);
      press(B_PWR);
      chk("pwr_zero", state, 0);
      press(B_CHG);
      chk("chg_zero", power_in, 10);

      power_now = 10'd500;
      press(B_PWR);
      wait_run("s3", nt);
      press(B_MODE);
      chk("s3_mode", mode_in, 1);
      power_now = 10'd21;
      step();
      chk("p21_state", state, 2);
      chk("p21_alarm", low_alarm, 0);
      power_now = 10'd20;
      step();
      chk("p20_state", state, 3);
      chk("p20_alarm", low_alarm, 1);
      chk("p20_onoff", on_off, 1);
      press(B_UP);
      chk("alarm_up", set_temp, 165);
      power_now = 10'd30;
      step();
      chk("p30_state", state, 2);
      chk("p30_alarm", low_alarm, 0);
      power_now = 10'd15;
      step();
      chk("p15_state", state, 3);
      power_now = 10'd0;
      step();
      chk("a0_state", state, 0);
      chk("a0_pin", power_in, 0);
      chk("a0_mode", mode_in, 0);
      chk("a0_alarm", low_alarm, 0);

      press(B_CHG);
      power_now = 10'd500;
      press(B_PWR);
      wait_run("s4", nt);
      power_now = 10'd57;
      step();
      press(B_PWR);
      chk("p57_state", state, 0);
      chk("p57_pin", power_in, 57);

      // Power press coincident with empty: forced-off wins.
      power_now = 10'd500;
      press(B_PWR);
      wait_run("s5", nt);
      power_now = 10'd0;
      press(B_PWR);
      chk("pe_state", state, 0);
      chk("pe_pin", power_in, 0);

      press(B_CHG);
      power_now = 10'd500;
      press(B_PWR);
      wait_run("s6", nt);
      press(B_MODE);
      press(B_UP);
      chk("s6_temp", set_temp, 170);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rr_state", state, 0);
      chk("rr_temp", set_temp, 250);
      chk("rr_pin", power_in, 100);
      chk("rr_onoff", on_off, 0);
      chk("rr_mode", mode_in, 0);
      chk("rr_alarm", low_alarm, 0);
      chk("rr_tick", tick, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
